spi_lcd_rx: RTL and testbench
=============================

// Module: spi_lcd_rx
// PURPOSE
//  SPI mode-0 slave receiver: the panel-side counterpart of the LCD transmitter's 4-wire bus (SCK, MOSI, NCS, DC).
//  Oversamples the bus with the system clock, assembles 8-bit words MSB-first and tags each with DC.
//  Queues each word in a FIFO for a downstream consumer (display emulator / bus monitor / loopback checker).
//  Reports overruns and truncated frames.
// PARAMETERS
//  FIFO_BITS   4   log2 depth of the RX FIFO (16 entries)
//  SYNC_STAGES 2   synchronizer flops on SCK/MOSI/NCS/DC (min 2)
// PORTS
//  clk          in   1  system clock; the only clock
//  reset        in   1  synchronous, active-high reset
//  sck          in   1  SPI clock from master; async to clk; idle low
//  mosi         in   1  SPI data, MSB first
//  ncs          in   1  chip select, active low
//  dc           in   1  data/command tag, sampled with bit 0 of each byte
//  rreq         in   1  consumer read request; hold until rack
//  rack         out  1  read acknowledge; data_out valid while rack=1
//  data_out     out  9  {dc, byte}
//  empty        out  1  FIFO empty
//  full         out  1  FIFO full
//  overrun      out  1  sticky: completed byte dropped because FIFO full
//  frame_error  out  1  sticky: NCS deasserted with 1..7 bits received
//  clear_errors in   1  one-cycle pulse; clears overrun and frame_error
//  byte_count   out 16  bytes successfully queued since reset; wraps at 0xFFFF->0
// BEHAVIOUR
//  Reset: rack=0, empty=1, full=0, overrun=0, frame_error=0, byte_count=0,
//   bit counter=0, shift reg=0, synchronizers loaded idle (sck=0, ncs=1). Reset mid-byte discards the partial byte.
//  Sampling: all bus inputs pass SYNC_STAGES flops. sck rise = sync_sck & !sck_d (one cycle after last sync stage).
//  Bus timing: SCK high and low phases each >= 3 clk. The LCD transmitter at CLOCK_DIVIDER=4 (4 clk per phase) complies.
//  FSM:
//   IDLE: sync_ncs=1. Bit counter held at 0. -> SHIFT when sync_ncs=0.
//   SHIFT: on each sck rise: shift <= {shift[6:0], mosi}, cnt++.
//    On the 8th rise: capture {dc, shift[6:0], mosi}, cnt <= 0, raise push for exactly 1 clk.
//    -> IDLE on sync_ncs=1. If cnt != 0 at that moment: frame_error <= 1 and the partial byte is discarded.
//  Byte boundaries:
//   The transmitter toggles NCS per byte. Back-to-back bytes with NCS held low are also legal; the counter simply rolls over.
//   An sck rise in the same cycle that sync_ncs goes high is ignored.
//  FIFO write:
//   push with full=0 -> word written, byte_count++ in the same cycle.
//   push with full=1 -> word dropped, overrun <= 1, byte_count unchanged.
//   Push and pop in the same cycle while full -> the word is still dropped (fullness is judged before the pop).
//  FIFO read: req/ack handshake.
//   Consumer raises rreq. rack rises 1 clk later if empty=0 (data_out valid while rack=1).
//   Consumer drops rreq after seeing rack. rack falls the next clk.
//   One word is popped per rreq pulse. rreq while empty -> rack stays 0 until a word arrives.
//  Write-to-read latency: empty falls 1 clk after push. The last SCK rise to empty=0 is SYNC_STAGES+2 clk.
//  Errors: sticky until clear_errors. If a new error and clear_errors occur in the same cycle, the error wins (flag stays 1).
//  Width/wrap: cnt is 3 bits, modulo 8. byte_count wraps silently. The FIFO pointers wrap modulo 2^FIFO_BITS.
// STRUCTURE
//  Shared package: SPI_WORD_W=9, DC bit index=8, FSM state encoding (ST_IDLE, ST_SHIFT).
//  Sub-modules:
//   - the existing fifo module: WIDTH=9, SIZE_BITS=FIFO_BITS, ports wreq/wack/rreq/rack.
//     It takes active-low nrst, so drive nrst = !reset.
//   - spi_rx_sync: SYNC_STAGES flop chain + sck edge detect. The only new sub-module.
// TESTING
//  1. Drive the LCD transmitter (CLOCK_DIVIDER=4) with {ncs=0,dc=0,0x2A}, {0,1,0x55}, {0,1,0xFF}
//     -> read 0x02A, 0x155, 0x1FF in order; byte_count=3; no errors.
//  2. NCS low, clock 5 bits of 0xA5, raise NCS -> frame_error=1, empty stays 1.
//     Then a full byte 0x3C with dc=1 -> 0x13C read correctly.
//  3. No reads, send 17 bytes 0x00..0x10 with FIFO_BITS=4 -> full=1, overrun=1, byte_count=16.
//     Drain -> exactly 0x000..0x00F.
//  4. Byte 0x81 completes in the same cycle as clear_errors while overrun=1 -> overrun ends 0 (push not full).
//     Repeat with FIFO full -> overrun ends 1.
//  5. Assert reset at the 4th SCK rise of 0xC3 -> all outputs at reset values.
//     Next full byte 0x5A -> 0x05A, no frame_error.
//  6. Hold NCS low across two bytes 0x12,0x34 -> two words queued.
//     Hold rreq high while empty, then send 0x77 -> rack rises SYNC_STAGES+3 clk after the final SCK rise.

Source files
------------

// File: rtl/spi_lcd_rx_pkg.sv
//==============================================================================
// Module      : spi_lcd_rx_pkg
// Description : Shared definitions for the SPI LCD-bus receiver. This file
//               holds the word width, the DC tag position, the bit counter
//               width and the receiver FSM state encoding.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package spi_lcd_rx_pkg;

  // Each received word is {dc, byte}.
  localparam int SPI_WORD_W = 9;
  localparam int DC_BIT     = 8;
  localparam int BIT_CNT_W  = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_e;

  function automatic logic [SPI_WORD_W-1:0] make_word(input logic dc, input logic [7:0] b);
    return {dc, b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo.sv
//==============================================================================
// Module      : fifo
// Description : Synchronous FIFO with a write-request/acknowledge port and a
//               read req/ack handshake.
//   clk   in            clock
//   nrst  in            synchronous active-low reset
//   wreq  in            write request (one word per cycle it is high)
//   wdata in  WIDTH     write data
//   wack  out           write accepted (wreq while not full)
//   rreq  in            read request, held by the consumer until rack
//   rack  out           read acknowledge; rdata valid while high
//   rdata out WIDTH     read data
//   empty out           no words stored
//   full  out           2^SIZE_BITS words stored
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fifo #(
  parameter int WIDTH     = 9,
  parameter int SIZE_BITS = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             wreq,
  input  logic [WIDTH-1:0] wdata,
  output logic             wack,
  input  logic             rreq,
  output logic             rack,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 1 << SIZE_BITS;

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit tells full and empty apart.
  logic [SIZE_BITS:0] wptr_q, rptr_q;
  logic               rack_q;
  logic [WIDTH-1:0]   rdata_q;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[SIZE_BITS] != rptr_q[SIZE_BITS]) &&
                 (wptr_q[SIZE_BITS-1:0] == rptr_q[SIZE_BITS-1:0]);
  // Fullness is judged on the registered pointers, so a pop in the same
  // cycle does not make room for the incoming word.
  assign wack  = wreq && !full;
  assign rack  = rack_q;
  assign rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (wack) begin
      mem_q[wptr_q[SIZE_BITS-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      rack_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (wack) begin
        wptr_q <= wptr_q + 1'b1;
      end
      // The word is popped as rack rises and is held in rdata until the
      // consumer drops its request.
      if (rack_q) begin
        if (!rreq) begin
          rack_q <= 1'b0;
        end
      end else if (rreq && !empty) begin
        rack_q  <= 1'b1;
        rdata_q <= mem_q[rptr_q[SIZE_BITS-1:0]];
        rptr_q  <= rptr_q + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_rx_sync.sv
//==============================================================================
// Module      : spi_rx_sync
// Description : Synchronizer chain for the four SPI bus lines plus SCK rising
//               edge detection in the clk domain.
//   clk        in   system clock
//   reset      in   synchronous active-high reset (loads idle bus: sck=0, ncs=1)
//   sck_i      in   raw SPI clock
//   mosi_i     in   raw SPI data
//   ncs_i      in   raw chip select (active low)
//   dc_i       in   raw data/command tag
//   mosi_o     out  synchronized MOSI
//   ncs_o      out  synchronized NCS
//   dc_o       out  synchronized DC
//   sck_rise_o out  one-cycle pulse on a synchronized SCK rising edge
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sck_i,
  input  logic mosi_i,
  input  logic ncs_i,
  input  logic dc_i,
  output logic mosi_o,
  output logic ncs_o,
  output logic dc_o,
  output logic sck_rise_o
);

  // Bit order within each stage: {dc, ncs, mosi, sck}.
  localparam logic [3:0] C_IDLE = 4'b0100;

  logic [3:0] sync_q [SYNC_STAGES];
  logic       sck_d_q;
  logic [3:0] last;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= C_IDLE;
      end
      sck_d_q <= 1'b0;
    end else begin
      sync_q[0] <= {dc_i, ncs_i, mosi_i, sck_i};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      sck_d_q <= sync_q[SYNC_STAGES-1][0];
    end
  end

  assign last       = sync_q[SYNC_STAGES-1];
  assign sck_rise_o = last[0] && !sck_d_q;
  assign mosi_o     = last[1];
  assign ncs_o      = last[2];
  assign dc_o       = last[3];

endmodule

`default_nettype wire

// File: rtl/spi_lcd_rx.sv
//==============================================================================
// Module      : spi_lcd_rx
// Description : SPI mode-0 slave receiver for the 4-wire LCD bus. It
//               assembles MSB-first bytes, tags them with DC and queues the
//               resulting words in a FIFO that the consumer reads over a
//               req/ack handshake. Overruns and truncated frames are reported.
//   clk          in      system clock
//   reset        in      synchronous active-high reset
//   sck/mosi/ncs/dc in   SPI bus (asynchronous to clk)
//   rreq         in      read request, held until rack
//   rack         out     read acknowledge; data_out valid while high
//   data_out     out 9   {dc, byte}
//   empty/full   out     FIFO status
//   overrun      out     sticky: completed byte dropped on a full FIFO
//   frame_error  out     sticky: NCS rose with 1..7 bits received
//   clear_errors in      clears both sticky flags (a new error wins)
//   byte_count   out 16  bytes queued since reset, wrapping
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_lcd_rx
  import spi_lcd_rx_pkg::*;
#(
  parameter int FIFO_BITS   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  mosi,
  input  logic                  ncs,
  input  logic                  dc,
  input  logic                  rreq,
  output logic                  rack,
  output logic [SPI_WORD_W-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  overrun,
  output logic                  frame_error,
  input  logic                  clear_errors,
  output logic [15:0]           byte_count
);

  logic mosi_s, ncs_s, dc_s, sck_rise;

  spi_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .reset      (reset),
    .sck_i      (sck),
    .mosi_i     (mosi),
    .ncs_i      (ncs),
    .dc_i       (dc),
    .mosi_o     (mosi_s),
    .ncs_o      (ncs_s),
    .dc_o       (dc_s),
    .sck_rise_o (sck_rise)
  );

  rx_state_e             state_q, state_d;
  logic [BIT_CNT_W-1:0]  cnt_q;
  logic [6:0]            shift_q;
  logic                  push_q;
  logic [SPI_WORD_W-1:0] word_q;
  logic                  overrun_q, frame_error_q;
  logic [15:0]           byte_count_q;

  logic shift_en;
  logic abort_partial;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!ncs_s) state_d = ST_SHIFT;
      ST_SHIFT: if (ncs_s)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs. An SCK rise coinciding with NCS release is ignored.
  always_comb begin
    shift_en      = 1'b0;
    abort_partial = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        if (ncs_s) begin
          abort_partial = (cnt_q != '0);
        end else begin
          shift_en = sck_rise;
        end
      end
      default: ;
    endcase
  end

  // Shift register and bit counter. Only the low seven bits of the shifter
  // are kept; the eighth bit comes straight from MOSI when the word forms.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
      push_q  <= 1'b0;
      word_q  <= '0;
    end else begin
      push_q <= 1'b0;
      if (shift_en) begin
        shift_q <= {shift_q[5:0], mosi_s};
        cnt_q   <= cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          word_q <= make_word(dc_s, {shift_q, mosi_s});
          push_q <= 1'b1;
        end
      end else if (state_q != ST_SHIFT || ncs_s) begin
        cnt_q   <= '0;
        shift_q <= '0;
      end
    end
  end

  logic nrst;
  logic wack;
  assign nrst = ~reset;

  fifo #(
    .WIDTH     (SPI_WORD_W),
    .SIZE_BITS (FIFO_BITS)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .wreq  (push_q),
    .wdata (word_q),
    .wack  (wack),
    .rreq  (rreq),
    .rack  (rack),
    .rdata (data_out),
    .empty (empty),
    .full  (full)
  );

  // Sticky error flags; a new error takes priority over a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q     <= 1'b0;
      frame_error_q <= 1'b0;
      byte_count_q  <= '0;
    end else begin
      if (push_q && full) begin
        overrun_q <= 1'b1;
      end else if (clear_errors) begin
        overrun_q <= 1'b0;
      end

      if (abort_partial) begin
        frame_error_q <= 1'b1;
      end else if (clear_errors) begin
        frame_error_q <= 1'b0;
      end

      if (wack) begin
        byte_count_q <= byte_count_q + 16'd1;
      end
    end
  end

  assign overrun     = overrun_q;
  assign frame_error = frame_error_q;
  assign byte_count  = byte_count_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_lcd_rx.sv
//==============================================================================
// Module      : tb_spi_lcd_rx
// Description : Directed self-checking bench for spi_lcd_rx. A bus driver
//               mimics the LCD transmitter at 4 clk per SCK phase; expected
//               words go into a scoreboard queue and are compared on reads.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_spi_lcd_rx;

  localparam int TB_FIFO_BITS = 4;
  localparam int TB_SYNC      = 2;
  localparam int TB_DEPTH     = 1 << TB_FIFO_BITS;

  logic        clk = 1'b0;
  logic        reset, sck, mosi, ncs, dc, rreq, clear_errors;
  logic        rack, empty, full, overrun, frame_error;
  logic [8:0]  data_out;
  logic [15:0] byte_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_rise = 0;
  int rack_rise_cyc = -1;
  logic rack_prev = 1'b0;
  logic [8:0] sb [$];
  int exp_bc = 0;

  spi_lcd_rx #(
    .FIFO_BITS   (TB_FIFO_BITS),
    .SYNC_STAGES (TB_SYNC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sck          (sck),
    .mosi         (mosi),
    .ncs          (ncs),
    .dc           (dc),
    .rreq         (rreq),
    .rack         (rack),
    .data_out     (data_out),
    .empty        (empty),
    .full         (full),
    .overrun      (overrun),
    .frame_error  (frame_error),
    .clear_errors (clear_errors),
    .byte_count   (byte_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rack && !rack_prev) rack_rise_cyc = cyc;
    rack_prev = rack;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Record the word the transmitter just sent, as the receiver should see it.
  task automatic expect_word(input logic [8:0] w);
    if (sb.size() < TB_DEPTH) begin
      sb.push_back(w);
      exp_bc++;
    end
  endtask

  // Clock out the top n bits of b, MSB first, 4 clk per phase.
  task automatic send_bits(input logic [7:0] b, input logic d, input int n);
    for (int i = 7; i >= 8 - n; i--) begin
      mosi = b[i];
      dc   = d;
      sck  = 1'b0;
      tick(4);
      sck  = 1'b1;
      last_rise = cyc;
      tick(4);
    end
    sck = 1'b0;
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    ncs = 1'b0;
    tick(4);
    send_bits(b, d, 8);
    ncs = 1'b1;
    tick(4);
    expect_word({d, b});
  endtask

  // 0x81 whose completing push coincides with a clear_errors pulse.
  task automatic send_81_with_clear();
    ncs = 1'b0;
    tick(4);
    send_bits(8'h81, 1'b0, 7);
    mosi = 1'b1;
    sck  = 1'b0;
    tick(4);
    sck  = 1'b1;
    tick(TB_SYNC + 1);
    clear_errors = 1'b1;
    tick(1);
    clear_errors = 1'b0;
    sck = 1'b0;
    tick(4);
    ncs = 1'b1;
    tick(4);
    expect_word(9'h081);
  endtask

  task automatic read_word(input string tag);
    int n;
    logic [8:0] exp;
    rreq = 1'b1;
    n = 0;
    while (!rack && n < 40) begin
      tick(1);
      n++;
    end
    check({tag, "_rack"}, 32'(rack), 32'd1);
    if (rack) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL %s_sb: observed extra word 0x%0h expected none", tag, data_out);
      end
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        check(tag, 32'(data_out), 32'(exp));
      end
    end
    rreq = 1'b0;
    n = 0;
    while (rack && n < 5) begin
      tick(1);
      n++;
    end
    check({tag, "_rack_fall"}, 32'(n), 32'd1);
  endtask

  initial begin
    reset = 1'b1; sck = 1'b0; mosi = 1'b0; ncs = 1'b1; dc = 1'b0;
    rreq = 1'b0; clear_errors = 1'b0;
    tick(4);
    reset = 1'b0;
    tick(1);
    check("rst_rack",   32'(rack),        32'd0);
    check("rst_empty",  32'(empty),       32'd1);
    check("rst_full",   32'(full),        32'd0);
    check("rst_ovr",    32'(overrun),     32'd0);
    check("rst_ferr",   32'(frame_error), 32'd0);
    check("rst_bcount", 32'(byte_count),  32'd0);

    // 1: three transmitter bytes with NCS toggled per byte
    send_byte(8'h2A, 1'b0);
    send_byte(8'h55, 1'b1);
    send_byte(8'hFF, 1'b1);
    check("t1_bcount", 32'(byte_count), 32'd3);
    read_word("t1_w0");
    read_word("t1_w1");
    read_word("t1_w2");
    check("t1_empty", 32'(empty),       32'd1);
    check("t1_ovr",   32'(overrun),     32'd0);
    check("t1_ferr",  32'(frame_error), 32'd0);

    // 2: truncated frame, then a good byte
    ncs = 1'b0;
    tick(4);
    send_bits(8'hA5, 1'b0, 5);
    ncs = 1'b1;
    tick(6);
    check("t2_ferr",   32'(frame_error), 32'd1);
    check("t2_empty",  32'(empty),       32'd1);
    check("t2_bcount", 32'(byte_count),  32'(exp_bc));
    clear_errors = 1'b1;
    tick(1);
    clear_errors = 1'b0;
    tick(1);
    check("t2_ferr_clr", 32'(frame_error), 32'd0);
    send_byte(8'h3C, 1'b1);
    read_word("t2_w");
    check("t2_ferr_after", 32'(frame_error), 32'd0);

    // 3: 17 bytes without reading -> one overrun
    for (int i = 0; i <= 16; i++) send_byte(8'(i), 1'b0);
    check("t3_full",   32'(full),       32'd1);
    check("t3_ovr",    32'(overrun),    32'd1);
    check("t3_bcount", 32'(byte_count), 32'(exp_bc));
    check("t3_sbsize", 32'(sb.size()),  32'(TB_DEPTH));
    for (int i = 0; i < TB_DEPTH; i++) read_word("t3_drain");
    check("t3_empty", 32'(empty), 32'd1);
    check("t3_nfull", 32'(full),  32'd0);

    // 4: clear coinciding with a push, not full then full
    send_81_with_clear();
    check("t4_ovr_cleared", 32'(overrun),    32'd0);
    check("t4_bcount",      32'(byte_count), 32'(exp_bc));
    read_word("t4_w");
    for (int i = 0; i < TB_DEPTH; i++) send_byte(8'h40 + 8'(i), 1'b1);
    check("t4_full", 32'(full), 32'd1);
    send_81_with_clear();
    check("t4_ovr_wins",  32'(overrun),    32'd1);
    check("t4_bcount_ff", 32'(byte_count), 32'(exp_bc));
    for (int i = 0; i < TB_DEPTH; i++) read_word("t4_drain");
    clear_errors = 1'b1;
    tick(1);
    clear_errors = 1'b0;
    tick(1);

    // 5: reset at the fourth SCK rise of 0xC3
    ncs = 1'b0;
    tick(4);
    send_bits(8'hC3, 1'b0, 3);
    mosi = 1'b0;
    sck  = 1'b1;
    tick(1);
    reset = 1'b1;
    sck   = 1'b0;
    ncs   = 1'b1;
    tick(6);
    reset = 1'b0;
    sb.delete();
    exp_bc = 0;
    tick(2);
    check("t5_rack",   32'(rack),        32'd0);
    check("t5_empty",  32'(empty),       32'd1);
    check("t5_full",   32'(full),        32'd0);
    check("t5_ovr",    32'(overrun),     32'd0);
    check("t5_ferr",   32'(frame_error), 32'd0);
    check("t5_bcount", 32'(byte_count),  32'd0);
    send_byte(8'h5A, 1'b0);
    read_word("t5_w");
    check("t5_ferr_after", 32'(frame_error), 32'd0);
    check("t5_bcount1",    32'(byte_count),  32'd1);

    // 6: two bytes with NCS held low, then a read waiting on an empty FIFO
    ncs = 1'b0;
    tick(4);
    send_bits(8'h12, 1'b0, 8);
    expect_word(9'h012);
    send_bits(8'h34, 1'b0, 8);
    expect_word(9'h034);
    ncs = 1'b1;
    tick(4);
    check("t6_ferr",   32'(frame_error), 32'd0);
    check("t6_bcount", 32'(byte_count),  32'(exp_bc));
    read_word("t6_w0");
    read_word("t6_w1");
    rreq = 1'b1;
    tick(10);
    check("t6_rack_wait", 32'(rack), 32'd0);
    rack_rise_cyc = -1;
    ncs = 1'b0;
    tick(4);
    send_bits(8'h77, 1'b0, 8);
    expect_word(9'h077);
    ncs = 1'b1;
    tick(4);
    check("t6_rack_up",  32'(rack), 32'd1);
    check("t6_rack_lat", 32'(rack_rise_cyc - last_rise), 32'(TB_SYNC + 3));
    check("t6_w2",       32'(data_out), 32'h077);
    if (sb.size() != 0) void'(sb.pop_front());
    rreq = 1'b0;
    tick(1);
    check("t6_rack_fall", 32'(rack),  32'd0);
    check("t6_empty",     32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
